digit_scroller: RTL



---
 rtl/scroller_pkg.sv | 19 +
 rtl/digit_scroller_seg7_decode.sv | 19 +
 rtl/digit_scroller.sv | 129 ++++++++++++
 3 files changed

// File: rtl/scroller_pkg.sv
// rtl/scroller_pkg.sv - shared types and segment constants for the digit scroller
package scroller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
  localparam logic [7:0] SEG_DASH       = 8'hBF;
  localparam logic [7:0] SEG_BLANK      = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; element 0 is digit 0
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/digit_scroller_seg7_decode.sv
// rtl/digit_scroller_seg7_decode.sv - 4-bit digit code to active-low 7-segment pattern
module seg7_decode
  import scroller_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [7:0] o_seg
);

  // Codes A-E render as a dash, F as blank
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_code <= 4'd9) begin
      o_seg = SEG_TABLE[i_code];
    end else if (i_code != 4'hF) begin
      o_seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/digit_scroller.sv
// rtl/digit_scroller.sv - scrolls decoded digits right-to-left across a multiplexed 7-segment display
module digit_scroller
  import scroller_pkg::*;
#(
  parameter int         NUM_DIGITS = 8,
  parameter int         SCAN_DIV   = 50000,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_tick,
  input  logic                  i_dec_valid,
  input  logic [3:0]            i_dec,
  output logic                  o_dec_ready,
  output logic [7:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic                  o_busy
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]         SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  state_t                         state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]     window_q, window_d;
  logic [3:0]                     pending_q, pending_d;
  logic                           pending_valid_q, pending_valid_d;
  logic                           tick_prev_q, tick_prev_d;
  logic [CW-1:0]                  scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]                  scan_idx_q, scan_idx_d;
  logic [7:0]                     seg_q, seg_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;
  logic                           busy_q, busy_d;

  logic                           shift_ev;
  logic                           accept;
  logic [7:0]                     dec_seg;

  seg7_decode u_decode (
    .i_code (window_q[scan_idx_q]),
    .o_seg  (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start)  state_d = RUN;
      RUN:     if (!i_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tick_prev resets high so a tick already high at reset release is not an edge
  assign shift_ev    = i_tick & ~tick_prev_q & (state_q == RUN);
  assign o_dec_ready = ~pending_valid_q | shift_ev;
  assign accept      = i_dec_valid & o_dec_ready;

  always_comb begin
    tick_prev_d     = i_tick;
    window_d        = window_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;

    if (shift_ev) begin
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
        window_d[k] = window_q[k-1];
      end
      window_d[0]     = pending_valid_q ? pending_q : BLANK_CODE;
      pending_valid_d = 1'b0;
    end

    if (accept) begin
      pending_d       = i_dec;
      pending_valid_d = 1'b1;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + CW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  always_comb begin
    an_d   = ~(AN_ONE << scan_idx_q);
    seg_d  = dec_seg;
    busy_d = pending_valid_d;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (window_d[k] != BLANK_CODE) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      window_q        <= {NUM_DIGITS{BLANK_CODE}};
      pending_q       <= BLANK_CODE;
      pending_valid_q <= 1'b0;
      tick_prev_q     <= 1'b1;
      scan_cnt_q      <= '0;
      scan_idx_q      <= '0;
      seg_q           <= SEG_BLANK;
      an_q            <= '1;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      window_q        <= window_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      tick_prev_q     <= tick_prev_d;
      scan_cnt_q      <= scan_cnt_d;
      scan_idx_q      <= scan_idx_d;
      seg_q           <= seg_d;
      an_q            <= an_d;
      busy_q          <= busy_d;
    end
  end

  assign o_seg  = seg_q;
  assign o_an   = an_q;
  assign o_busy = busy_q;

endmodule
